// File: rtl/vedic_div32by16.sv
// vedic_div32by16: sequential signed 32/16 divider with truncating semantics.
// It sits beside the 16x16 signed multiplier and undoes its product.
// The core is a radix-2 restoring divider that works on magnitudes and
// takes 32 steps. One more cycle applies the signs, checks the quotient
// range and registers the results.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | in_ready high; accept operands and latch magnitudes/signs
//   S_CALC | one restoring step per cycle, 32 steps (down-counter 31..0)
//   S_FIX  | apply signs, range-check, register quotient/remainder/flags
//   S_DONE | out_valid high, results held until out_ready
module vedic_div32by16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        ovf,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    // The running remainder is always below the divisor magnitude
    // (at most 0x7FFF), so 16 bits hold it between steps. The 17-bit width
    // that the restoring compare needs exists only in w_shift and w_trial.
    logic [15:0] r_prem;
    logic [31:0] r_qreg;
    logic [15:0] r_dmag;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_out_valid;
    logic [15:0] r_quot;
    logic [15:0] r_rem;
    logic        r_ovf;
    logic        r_div_zero;

    logic [31:0] w_dvd_mag;
    logic [15:0] w_dvs_mag;
    logic        w_dvs_zero;
    logic        w_accept;
    logic [16:0] w_shift;
    logic [16:0] w_trial;
    logic        w_q_bit;
    logic [16:0] w_prem_next;
    logic [15:0] w_q_neg;
    logic [15:0] w_r_neg;
    logic        w_q_ovf;
    logic [15:0] w_q_fix;
    logic [15:0] w_r_fix;

    // Operand magnitudes. Negating 0x80000000 or 0x8000 yields the same bit
    // pattern, which is the correct unsigned magnitude, so no extra width is needed.
    assign w_dvd_mag  = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign w_dvs_mag  = divisor[15]  ? (~divisor + 16'd1)  : divisor;
    assign w_dvs_zero = (divisor == 16'd0);
    assign w_accept   = in_valid && (r_state == S_IDLE);

    // One restoring step: bring in the next dividend bit, then try to subtract.
    assign w_shift     = {r_prem, r_qreg[31]};
    assign w_trial     = w_shift - {1'b0, r_dmag};
    assign w_q_bit     = ~w_trial[16];
    assign w_prem_next = w_q_bit ? w_trial : w_shift;

    // Sign application and range check on the 32-bit quotient magnitude.
    // A negative quotient may reach magnitude 0x8000. A positive quotient stops at 0x7FFF.
    assign w_q_neg = ~r_qreg[15:0] + 16'd1;
    assign w_r_neg = ~r_prem + 16'd1;
    assign w_q_ovf = r_sign_q ? (r_qreg > 32'h0000_8000) : (r_qreg > 32'h0000_7FFF);

    always_comb begin
        w_q_fix = r_qreg[15:0];
        if (w_q_ovf) begin
            w_q_fix = r_sign_q ? 16'h8000 : 16'h7FFF;
        end else if (r_sign_q) begin
            w_q_fix = w_q_neg;
        end
    end

    // A zero remainder stays zero whatever the sign of the dividend.
    always_comb begin
        w_r_fix = r_prem;
        if (r_sign_r && (r_prem != 16'd0)) begin
            w_r_fix = w_r_neg;
        end
    end

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_prem      <= 16'd0;
            r_qreg      <= 32'd0;
            r_dmag      <= 16'd0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_out_valid <= 1'b0;
            r_quot      <= 16'd0;
            r_rem       <= 16'd0;
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_q <= dividend[31] ^ divisor[15];
                        r_sign_r <= dividend[31];
                        r_qreg   <= w_dvd_mag;
                        r_dmag   <= w_dvs_mag;
                        r_prem   <= 16'd0;
                        r_cnt    <= 5'd31;
                        if (w_dvs_zero) begin
                            // Divide by zero skips the datapath and presents the result on the accept edge.
                            r_quot      <= 16'hFFFF;
                            r_rem       <= dividend[15:0];
                            r_ovf       <= 1'b0;
                            r_div_zero  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_prem <= w_prem_next[15:0];
                    r_qreg <= {r_qreg[30:0], w_q_bit};
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    r_quot      <= w_q_fix;
                    r_rem       <= w_r_fix;
                    r_ovf       <= w_q_ovf;
                    r_div_zero  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign ovf       = r_ovf;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_vedic_div32by16.sv
// Scoreboard bench for vedic_div32by16. The driver pushes hand-computed
// results. A monitor pops one result and compares it on every out_valid/out_ready handshake.
module tb_vedic_div32by16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        ovf;
    logic        div_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    vedic_div32by16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: one pop per handshake; out_valid drops right after the handshake edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                timeout_fail("unexpected_result");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient", {16'd0, quotient}, {16'd0, e.q});
                check("remainder", {16'd0, remainder}, {16'd0, e.r});
                check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            end
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) timeout_fail("in_ready_wait");
    endtask

    // Issue one operation. exp_lat counts the edges from the accept edge until out_valid is seen.
    // hold > 0 stalls the consumer for that many cycles in DONE.
    task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic eo, input logic ed,
                         input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        wait_ready();
        e.q = eq; e.r = er; e.ovf = eo; e.dz = ed;
        sb_q.push_back(e);
        if (hold > 0) out_ready = 1'b0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            timeout_fail("out_valid_wait");
        end else begin
            check("latency", lat, exp_lat);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("hold_out_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
                check("hold_quotient", {16'd0, quotient}, {16'd0, eq});
                check("hold_remainder", {16'd0, remainder}, {16'd0, er});
                in_valid = (i % 2 == 0);
                dividend = 32'd99;
                divisor  = 16'd3;
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("release_out_valid", {31'd0, out_valid}, 32'd0);
            check("release_in_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 32'd0;
        divisor   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Round trip of the multiplier product -300 * 7.
        do_op(32'hFFFF_F7CC, 16'h0007, 16'hFED4, 16'h0000, 1'b0, 1'b0, 33, 0);
        // Sign rules.
        do_op(32'd100,       16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 33, 0);
        do_op(32'hFFFF_FF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 33, 0);
        do_op(32'hFFFF_FF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 33, 0);
        do_op(32'h3FFF_0001, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 33, 0);
        // Divisor -32768.
        do_op(32'hFFFF_0000, 16'h8000, 16'h0002, 16'h0000, 1'b0, 1'b0, 33, 0);
        // Overflow and range boundaries.
        do_op(32'h4000_0000, 16'h0002, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 33, 0);
        do_op(32'h8000_0000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 33, 0);
        do_op(32'h8000_0000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 33, 0);
        do_op(32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 33, 0);
        // 0x7FFFFFFF / -32768: magnitude quotient is 0xFFFF, giving -65535 (overflow); remainder is +0x7FFF.
        do_op(32'h7FFF_FFFF, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 33, 0);
        // Divide by zero: the result is registered on the accept edge itself.
        do_op(32'h0000_04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b0, 1'b1, 0, 0);
        // Backpressure for 5 cycles: 1234567 / 1000 = 1234 r 567. Then back-to-back operations.
        do_op(32'd1234567,   16'd1000, 16'h04D2, 16'h0237, 1'b0, 1'b0, 33, 5);
        do_op(32'hFFFF_FF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 33, 0);
        do_op(32'h8000_0000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 33, 0);

        // Abort mid-CALC. The quotient (0x8000) and ovf from the last result must clear at once.
        wait_ready();
        dividend = 32'd1000;
        divisor  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        check("abort_div_zero", {31'd0, div_zero}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", {31'd0, out_valid}, 32'd0);
        do_op(32'd6, 16'd3, 16'h0002, 16'h0000, 1'b0, 1'b0, 33, 0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
